tinyalu_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one tinyalu instance between NUM_REQ requesters.
- Accepts one operation at a time from requesters on a valid/ready handshake.
- Drives the ALU start/op/operand pins and holds start until done is seen.
- Returns the 16-bit result to the granted requester with a one-cycle response pulse.
- Sits between the requester agents (or upstream datapath blocks) and the tinyalu.

---
 rtl/tinyalu_arbiter.sv | 165 ++++++++++++++++
 tb/tb_tinyalu_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinyalu_arbiter.sv
// Round-robin arbiter and sequencer that shares one tinyalu between NUM_REQ
// requesters. One operation is outstanding at a time: IDLE accepts a request,
// EXEC holds alu_start until done (or timeout), RESP pulses the response.
module tinyalu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_a,
  input  logic [NUM_REQ*8-1:0]   req_b,
  input  logic [NUM_REQ*3-1:0]   req_op,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [15:0]            rsp_result,
  output logic                   rsp_error,
  output logic                   busy,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic [2:0]             alu_op,
  output logic                   alu_start,
  input  logic                   alu_done,
  input  logic [15:0]            alu_result
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Opcodes that need the ALU; everything else (no_op, rst_op, 101, 110)
  // is answered locally with a zero result.
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b010) || (op == 3'b011) || (op == 3'b100);
  endfunction

  state_t             state;
  state_t             next_state;
  logic [IDX_W-1:0]   grant_q;     // round-robin pointer and owner of the op
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   cand;
  logic               any_valid;
  logic               accept;
  logic               exec_done;
  logic               exec_timeout;
  logic [CNT_W-1:0]   cnt;

  logic [7:0] a_arr  [NUM_REQ];
  logic [7:0] b_arr  [NUM_REQ];
  logic [2:0] op_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i]  = req_a[8*i +: 8];
    assign b_arr[i]  = req_b[8*i +: 8];
    assign op_arr[i] = req_op[3*i +: 3];
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Round-robin pick: first asserted request after the pointer, wrapping.
  // NOTE: every variable gets a default before any conditional write so the
  // combinational block cannot infer a latch.
  always_comb begin
    grant_idx = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(grant_q) + k) % NUM_REQ);
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Next-state logic, handshake and control strobes for the datapath.
  always_comb begin
    next_state   = state;
    accept       = 1'b0;
    exec_done    = 1'b0;
    exec_timeout = 1'b0;
    req_ready    = '0;
    case (state)
      IDLE: begin
        if (any_valid && !reset) begin
          accept               = 1'b1;
          req_ready[grant_idx] = 1'b1;
          next_state           = is_alu_op(op_arr[grant_idx]) ? EXEC : RESP;
        end
      end
      EXEC: begin
        // done has priority over a timeout hit in the same cycle
        if (alu_done) begin
          exec_done  = 1'b1;
          next_state = RESP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          exec_timeout = 1'b1;
          next_state   = RESP;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand latch, ALU start, cycle counter and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q    <= IDX_W'(NUM_REQ - 1);
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_start  <= 1'b0;
      cnt        <= '0;
      rsp_result <= '0;
      rsp_error  <= 1'b0;
    end else begin
      if (accept) begin
        grant_q   <= grant_idx;
        alu_a     <= a_arr[grant_idx];
        alu_b     <= b_arr[grant_idx];
        alu_op    <= op_arr[grant_idx];
        alu_start <= is_alu_op(op_arr[grant_idx]);
        cnt       <= '0;
        if (!is_alu_op(op_arr[grant_idx])) begin
          rsp_result <= '0;
          rsp_error  <= 1'b0;
        end
      end
      if (state == EXEC) begin
        if (exec_done) begin
          alu_start  <= 1'b0;
          rsp_result <= alu_result;
          rsp_error  <= 1'b0;
        end else if (exec_timeout) begin
          alu_start  <= 1'b0;
          rsp_result <= '0;
          rsp_error  <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // One-cycle response pulse to the owner of the finished operation.
  always_comb begin
    rsp_valid = '0;
    if (state == RESP) rsp_valid[grant_q] = 1'b1;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Directed testbench for tinyalu_arbiter with a behavioural tinyalu model
// whose done latency is programmable (0 = never completes).
module tb_tinyalu_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*8-1:0] req_a = '0;
  logic [N*8-1:0] req_b = '0;
  logic [N*3-1:0] req_op = '0;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  rsp_valid;
  logic [15:0]   rsp_result;
  logic          rsp_error;
  logic          busy;
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [2:0]    alu_op;
  logic          alu_start;
  logic          alu_done = 1'b0;
  logic [15:0]   alu_result = '0;

  int checks = 0;
  int errors = 0;

  int lat = 1;
  int high_cycles = 0;
  logic spurious = 1'b0;

  tinyalu_arbiter #(.NUM_REQ(N), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .rsp_error(rsp_error), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  // ALU model: done rises in the lat-th cycle after the first start cycle.
  always @(posedge clk) begin
    #1;
    if (alu_start) high_cycles = high_cycles + 1;
    else           high_cycles = 0;
    alu_done = spurious || (alu_start && lat != 0 && high_cycles == lat + 1);
    case (alu_op)
      3'b001:  alu_result = {8'h00, alu_a} + {8'h00, alu_b};
      3'b010:  alu_result = {8'h00, alu_a & alu_b};
      3'b011:  alu_result = {8'h00, alu_a ^ alu_b};
      3'b100:  alu_result = {8'h00, alu_a} * {8'h00, alu_b};
      default: alu_result = 16'h0000;
    endcase
  end

  task automatic set_req(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op);
    req_a[idx*8 +: 8] = a;
    req_b[idx*8 +: 8] = b;
    req_op[idx*3 +: 3] = op;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, busy, alu_start} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b rsp_valid=%b busy=%b start=%b expected all 0",
               req_ready, rsp_valid, busy, alu_start);
    end
    checks++;
    if ({rsp_result, rsp_error, alu_a, alu_b, alu_op} !== '0) begin
      errors++;
      $display("FAIL reset_data: result=%h err=%b a=%h b=%h op=%b expected all 0",
               rsp_result, rsp_error, alu_a, alu_b, alu_op);
    end
    reset = 1'b0;
  endtask

  // Issue one request from idx and follow it to its response.
  task automatic run_op(input string name, input int idx, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] op, input int latency,
                        input logic [15:0] exp_res, input logic exp_err,
                        input int exp_starts);
    logic [N-1:0] oh;
    int starts;
    int cyc;
    logic busy_ok;
    oh = '0;
    oh[idx] = 1'b1;
    @(negedge clk);
    lat = latency;
    set_req(idx, a, b, op);
    req_valid = oh;
    #1;
    checks++;
    if (req_ready !== oh) begin
      errors++;
      $display("FAIL %s_ready: got %b expected %b", name, req_ready, oh);
    end
    @(negedge clk);
    req_valid = '0;
    starts = 0;
    cyc = 0;
    busy_ok = 1'b1;
    while (rsp_valid === '0 && cyc < 40) begin
      if (alu_start === 1'b1) starts++;
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (rsp_valid !== oh) begin
      errors++;
      $display("FAIL %s_rsp_valid: got %b expected %b", name, rsp_valid, oh);
    end
    checks++;
    if (rsp_result !== exp_res || rsp_error !== exp_err) begin
      errors++;
      $display("FAIL %s_result: got %h err %b expected %h err %b",
               name, rsp_result, rsp_error, exp_res, exp_err);
    end
    checks++;
    if (starts != exp_starts || alu_start !== 1'b0 || !busy_ok) begin
      errors++;
      $display("FAIL %s_start: start cycles %0d (now %b, busy_ok %b) expected %0d (now 0, busy_ok 1)",
               name, starts, alu_start, busy_ok, exp_starts);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_after: rsp_valid=%b busy=%b expected 0 0", name, rsp_valid, busy);
    end
  endtask

  task automatic test_single_add();
    run_op("add", 0, 8'h12, 8'h34, 3'b001, 1, 16'h0046, 1'b0, 2);
  endtask

  task automatic test_mul_latency();
    run_op("mul", 2, 8'hFF, 8'hFF, 3'b100, 3, 16'hFE01, 1'b0, 4);
  endtask

  task automatic test_local_ops();
    run_op("nop", 1, 8'h11, 8'h22, 3'b000, 1, 16'h0000, 1'b0, 0);
    run_op("add_mid", 1, 8'h01, 8'h01, 3'b001, 1, 16'h0002, 1'b0, 2);
    run_op("rst_op", 1, 8'h33, 8'h44, 3'b111, 1, 16'h0000, 1'b0, 0);
    run_op("op101", 1, 8'h55, 8'h66, 3'b101, 1, 16'h0000, 1'b0, 0);
  endtask

  task automatic test_timeout();
    run_op("add_pre", 3, 8'h20, 8'h22, 3'b001, 1, 16'h0042, 1'b0, 2);
    run_op("timeout", 3, 8'h09, 8'h09, 3'b100, 0, 16'h0000, 1'b1, 15);
    run_op("add_post", 0, 8'h12, 8'h34, 3'b001, 1, 16'h0046, 1'b0, 2);
  endtask

  task automatic test_done_at_timeout();
    run_op("done_wins", 1, 8'h01, 8'h02, 3'b001, 14, 16'h0003, 1'b0, 15);
  endtask

  task automatic test_spurious_done();
    @(negedge clk);
    spurious = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== '0 || alu_start !== 1'b0) begin
      errors++;
      $display("FAIL idle_done: busy=%b rsp_valid=%b start=%b expected 0 0 0",
               busy, rsp_valid, alu_start);
    end
    spurious = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [15:0] exp_res [4] = '{16'h0046, 16'h0030, 16'h00CC, 16'h0100};
    logic [N-1:0] oh;
    int g;
    int cyc;
    logic ready_ok;
    apply_reset();
    lat = 1;
    set_req(0, 8'h12, 8'h34, 3'b001);
    set_req(1, 8'hF0, 8'h3C, 3'b010);
    set_req(2, 8'hF0, 8'h3C, 3'b011);
    set_req(3, 8'h10, 8'h10, 3'b100);
    req_valid = 4'hF;
    #1;
    for (int n = 0; n < 5; n++) begin
      g = order[n];
      oh = '0;
      oh[g] = 1'b1;
      cyc = 0;
      while (req_ready === '0 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (req_ready !== oh) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b expected %b", n, req_ready, oh);
      end
      @(negedge clk);
      cyc = 0;
      ready_ok = 1'b1;
      while (rsp_valid === '0 && cyc < 20) begin
        if (req_ready !== '0) ready_ok = 1'b0;
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (rsp_valid !== oh || rsp_result !== exp_res[g] || !ready_ok) begin
        errors++;
        $display("FAIL rr_rsp%0d: rsp_valid=%b result=%h ready_quiet=%b expected %b %h 1",
                 n, rsp_valid, rsp_result, ready_ok, oh, exp_res[g]);
      end
      @(negedge clk);
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_exec();
    int cyc;
    @(negedge clk);
    lat = 0;
    set_req(0, 8'h05, 8'h07, 3'b100);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (alu_start !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_exec_pre: start=%b busy=%b expected 1 1", alu_start, busy);
    end
    reset = 1'b1;
    set_req(1, 8'h02, 8'h03, 3'b001);
    req_valid = 4'b0011;
    @(negedge clk);
    checks++;
    if (alu_start !== 1'b0 || busy !== 1'b0 || rsp_valid !== '0 || req_ready !== '0) begin
      errors++;
      $display("FAIL mid_exec_reset: start=%b busy=%b rsp_valid=%b ready=%b expected 0 0 0 0",
               alu_start, busy, rsp_valid, req_ready);
    end
    reset = 1'b0;
    lat = 1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mid_exec_regrant: got %b expected 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    cyc = 0;
    while (rsp_valid === '0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_result !== 16'h0023 || rsp_error !== 1'b0) begin
      errors++;
      $display("FAIL mid_exec_rsp: rsp_valid=%b result=%h err=%b expected 0001 0023 0",
               rsp_valid, rsp_result, rsp_error);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_mul_latency();
    test_local_ops();
    test_timeout();
    test_spurious_done();
    test_done_at_timeout();
    test_round_robin();
    test_reset_mid_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
